// File: rtl/diff2_decoder_pkg.sv
// Shared definitions for both ends of the lag-difference coded link.
// Covers the decoder FSM state encoding and the default lag and counter width.
package diff2_decoder_pkg;

  localparam int unsigned DEFAULT_LAG   = 2;
  localparam int unsigned DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/diff2_decoder_sat_counter.sv
// Width-parameterised up-counter.
// It counts on enable, clears synchronously and holds at all-ones.
module diff2_decoder_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/diff2_decoder.sv
// Rebuilds the original bit stream from lag-LAG difference flags: x[n] = d[n] ^ x[n-LAG].
// It adds valid gating, history seeding, a warm-up FSM and a saturating ones counter.
module diff2_decoder
  import diff2_decoder_pkg::*;
#(
  parameter int unsigned LAG   = DEFAULT_LAG,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             seed_load,
  input  logic [LAG-1:0]   seed,
  output logic             out_valid,
  output logic             out,
  output logic             primed,
  output logic [CNT_W-1:0] ones_count
);

  localparam int unsigned WARM_W = $clog2(LAG + 1);

  state_t              state_q, state_d;
  logic [LAG-1:0]      hist_q, hist_d;
  logic [WARM_W-1:0]   warm_q, warm_d, warm_inc;
  logic                out_q, out_valid_q, primed_q;
  logic                accept;
  logic                x;

  // A seed load in the same cycle wins and drops the incoming flag.
  assign accept   = in_valid & ~seed_load;
  assign x        = in ^ hist_q[LAG-1];
  assign warm_inc = warm_q + WARM_W'(1);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    warm_d  = warm_q;
    if (seed_load) begin
      hist_d  = seed;
      state_d = RUN;
    end else if (in_valid) begin
      hist_d = LAG'({hist_q, x});
      unique case (state_q)
        IDLE: begin
          warm_d  = WARM_W'(1);
          state_d = (LAG == 1) ? RUN : WARMUP;
        end
        WARMUP: begin
          warm_d = warm_inc;
          if (warm_inc == WARM_W'(LAG)) state_d = RUN;
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hist_q      <= '0;
      warm_q      <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      warm_q      <= warm_d;
      out_valid_q <= accept;
      primed_q    <= (state_d == RUN);
      if (accept) out_q <= x;
    end
  end

  diff2_decoder_sat_counter #(.W(CNT_W)) u_ones_cnt (
    .clk     (clk),
    .clr_i   (reset),
    .en_i    (accept & x),
    .count_o (ones_count)
  );

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_diff2_decoder.sv
// Directed checks of diff2_decoder against hand-computed reconstruction vectors.
module tb_diff2_decoder;

  logic       clk = 1'b0;
  logic       reset, in_valid, in, seed_load;
  logic [1:0] seed;
  logic       out_valid, out, primed;
  logic [7:0] ones_count;
  logic       out_valid2, out2, primed2;
  logic [1:0] ones_count2;

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  diff2_decoder #(.LAG(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .seed_load(seed_load), .seed(seed), .out_valid(out_valid),
    .out(out), .primed(primed), .ones_count(ones_count)
  );

  diff2_decoder #(.LAG(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .seed_load(seed_load), .seed(seed), .out_valid(out_valid2),
    .out(out2), .primed(primed2), .ones_count(ones_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic d,
                      input logic sl, input logic [1:0] s);
    reset = r; in_valid = v; in = d; seed_load = sl; seed = s;
    @(posedge clk);
    #1;
  endtask

  logic [9:0] d1, x1;

  initial begin
    d1 = 10'b1110001000;   // bit i = d[i]: 0,0,0,1,0,0,0,1,1,1
    x1 = 10'b1100101000;   // bit i = x[i]: 0,0,0,1,0,1,0,0,1,1

    step(1, 0, 0, 0, 2'b00);
    step(1, 0, 0, 0, 2'b00);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_primed", 32'(primed), 0);
    chk("rst_ones", 32'(ones_count), 0);

    // Scenario 1: continuous stream.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, d1[i], 0, 2'b00);
      chk($sformatf("s1_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("s1_out_%0d", i), 32'(out), 32'(x1[i]));
      chk($sformatf("s1_primed_%0d", i), 32'(primed), (i >= 1) ? 1 : 0);
    end
    chk("s1_ones", 32'(ones_count), 4);
    step(0, 0, 1, 0, 2'b00);
    chk("s1_idle_valid", 32'(out_valid), 0);

    // Scenario 2: same stream with a three-cycle gap after the 4th sample.
    step(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, d1[i], 0, 2'b00);
      chk($sformatf("s2_out_%0d", i), 32'(out), 32'(x1[i]));
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          step(0, 0, 1'bx, 0, 2'b00);
          chk($sformatf("s2_gap_valid_%0d", g), 32'(out_valid), 0);
        end
      end
    end
    chk("s2_ones", 32'(ones_count), 4);

    // Scenario 3: seed load in RUN drops the concurrent sample.
    step(0, 1, 1, 1, 2'b10);
    chk("s3_drop_valid", 32'(out_valid), 0);
    chk("s3_primed", 32'(primed), 1);
    chk("s3_ones_kept", 32'(ones_count), 4);
    step(0, 1, 0, 0, 2'b00);
    chk("s3_out0", 32'(out), 1);
    step(0, 1, 0, 0, 2'b00);
    chk("s3_out1", 32'(out), 0);
    chk("s3_ones", 32'(ones_count), 5);

    // Scenario 4: seed from IDLE primes immediately.
    step(1, 0, 0, 0, 2'b00);
    chk("s4_primed_rst", 32'(primed), 0);
    step(0, 0, 0, 1, 2'b01);
    chk("s4_primed", 32'(primed), 1);
    chk("s4_valid", 32'(out_valid), 0);
    step(0, 1, 1, 0, 2'b00);
    chk("s4_out", 32'(out), 1);
    chk("s4_valid2", 32'(out_valid), 1);

    // Scenario 5: 2-bit counter saturates at 3.
    step(1, 0, 0, 0, 2'b00);
    begin
      logic [5:0] d5;
      int exp5 [6];
      d5 = 6'b000011;
      exp5 = '{1, 2, 3, 3, 3, 3};
      for (int i = 0; i < 6; i++) begin
        step(0, 1, d5[i], 0, 2'b00);
        chk($sformatf("s5_x_%0d", i), 32'(out2), 1);
        chk($sformatf("s5_cnt_%0d", i), 32'(ones_count2), 32'(exp5[i]));
      end
    end

    // Scenario 6: reset mid-stream.
    step(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) step(0, 1, d1[i+3], 0, 2'b00);
    chk("s6_pre_primed", 32'(primed), 1);
    step(1, 1, 1, 0, 2'b00);
    chk("s6_valid", 32'(out_valid), 0);
    chk("s6_out", 32'(out), 0);
    chk("s6_primed", 32'(primed), 0);
    chk("s6_ones", 32'(ones_count), 0);
    step(0, 1, 1, 0, 2'b00);
    chk("s6_out_after", 32'(out), 1);
    chk("s6_primed_after", 32'(primed), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
